// File: rtl/bscan_deframe_pkg.sv
// Shared constants and types for the BSCAN receive deframer: header field
// positions, FSM state encoding and the default FIFO entry layout.
package bscan_deframe_pkg;

    localparam int LEN_LSB     = 0;
    localparam int LEN_W       = 16;
    localparam int CHAN_LSB    = 16;
    localparam int DFLT_DATA_W = 32;
    localparam int DFLT_CHAN_W = 4;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    // Entry layout as stored in the FIFO, MSB first: {last, chan, data}.
    typedef struct packed {
        logic                   last;
        logic [DFLT_CHAN_W-1:0] chan;
        logic [DFLT_DATA_W-1:0] data;
    } entry_t;

    function automatic int entry_w(input int data_w, input int chan_w);
        return data_w + chan_w + 1;
    endfunction

endpackage

// File: rtl/bscan_deframe_fifo.sv
// Generic DEPTH-entry registered FIFO with ENA/RDY handshakes on both sides.
// No bypass path: a word written this cycle is visible at the head next cycle.
module bscan_deframe_fifo
    import bscan_deframe_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_ena,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             out_ena,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_ena && !w_full;
    assign w_pop    = out_ena;

    assign in_rdy   = !w_full;
    assign out_ena  = !w_empty && out_rdy;
    // Head is forced to zero when empty so the outputs come out of reset clean.
    assign out_data = w_empty ? '0 : r_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bscan_rx_deframer.sv
// Splits the BSCAN word stream into {channel, length} headers and tagged payload
// beats queued to the router. Optional counters under BSCAN_DEFRAME_STATS_EN.
module bscan_rx_deframer
    import bscan_deframe_pkg::*;
#(
    parameter int width  = DFLT_DATA_W,
    parameter int CHAN_W = DFLT_CHAN_W,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_enq__ENA,
    input  logic [width-1:0]  in_enq_v,
    output logic              in_enq__RDY,
    output logic              out_enq__ENA,
    output logic [width-1:0]  out_enq_v,
    output logic [CHAN_W-1:0] out_enq_chan,
    output logic              out_enq_last,
    input  logic              out_enq__RDY,
    output logic              err_zero_len
`ifdef BSCAN_DEFRAME_STATS_EN
    ,
    output logic [15:0]       stat_msgs,
    output logic [15:0]       stat_drops
`endif
);

    localparam int ENTRY_W = entry_w(width, CHAN_W);

    state_t            r_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [CHAN_W-1:0] r_chan;
    logic              r_err_zero_len;

    logic               w_accept;
    logic               w_push;
    logic               w_last;
    logic               w_hdr_zero;
    logic [LEN_W-1:0]   w_hdr_len;
    logic [CHAN_W-1:0]  w_hdr_chan;
    logic               w_fifo_in_rdy;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head_entry;

    assign w_hdr_len    = in_enq_v[LEN_LSB +: LEN_W];
    assign w_hdr_chan   = in_enq_v[CHAN_LSB +: CHAN_W];
    assign w_hdr_zero   = (w_hdr_len == '0);
    assign w_accept     = in_enq__ENA && in_enq__RDY;
    assign w_push       = w_accept && (r_state == PAY);
    assign w_last       = (r_remaining == LEN_W'(1));
    assign w_push_entry = {w_last, r_chan, in_enq_v};

    // Headers never enter the FIFO, so a full FIFO only stalls payload.
    assign in_enq__RDY  = (r_state == HDR) || w_fifo_in_rdy;
    assign err_zero_len = r_err_zero_len;

    assign out_enq_v    = w_head_entry[width-1:0];
    assign out_enq_chan = w_head_entry[width +: CHAN_W];
    assign out_enq_last = w_head_entry[ENTRY_W-1];

    bscan_deframe_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .in_ena   (w_push),
        .in_data  (w_push_entry),
        .in_rdy   (w_fifo_in_rdy),
        .out_ena  (out_enq__ENA),
        .out_data (w_head_entry),
        .out_rdy  (out_enq__RDY)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state        <= HDR;
            r_remaining    <= '0;
            r_chan         <= '0;
            r_err_zero_len <= 1'b0;
        end else begin
            r_err_zero_len <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_accept) begin
                        if (w_hdr_zero) begin
                            r_err_zero_len <= 1'b1;
                        end else begin
                            r_chan      <= w_hdr_chan;
                            r_remaining <= w_hdr_len;
                            r_state     <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last) begin
                            r_state <= HDR;
                        end
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

`ifdef BSCAN_DEFRAME_STATS_EN
    logic [15:0] r_stat_msgs;
    logic [15:0] r_stat_drops;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_msgs  <= '0;
            r_stat_drops <= '0;
        end else begin
            if (w_push && w_last) begin
                r_stat_msgs <= r_stat_msgs + 1'b1;
            end
            if (w_accept && (r_state == HDR) && w_hdr_zero) begin
                r_stat_drops <= r_stat_drops + 1'b1;
            end
        end
    end

    assign stat_msgs  = r_stat_msgs;
    assign stat_drops = r_stat_drops;
`else
    // Without stats the deframer carries no counters beyond the FSM.
`endif

endmodule

// File: tb/tb_bscan_rx_deframer.sv
// Scoreboard bench for bscan_rx_deframer: expected beats are queued as payload
// is driven and compared as the DUT emits them.
module tb_bscan_rx_deframer;
    import bscan_deframe_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_ena = 1'b0;
    logic [31:0] in_v = '0;
    logic        in_rdy;
    logic        out_ena;
    logic [31:0] out_v;
    logic [3:0]  out_chan;
    logic        out_last;
    logic        out_rdy = 1'b0;
    logic        err_zero_len;
`ifdef BSCAN_DEFRAME_STATS_EN
    logic [15:0] stat_msgs;
    logic [15:0] stat_drops;
`endif

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_err_pulses = 0;
    int     msgs_sent = 0;
    bit     bp_rand = 1'b0;
    entry_t sb[$];

    always #5 clk = ~clk;

    bscan_rx_deframer dut (
        .CLK          (clk),
        .nRST         (nrst),
        .in_enq__ENA  (in_ena),
        .in_enq_v     (in_v),
        .in_enq__RDY  (in_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq_chan (out_chan),
        .out_enq_last (out_last),
        .out_enq__RDY (out_rdy),
        .err_zero_len (err_zero_len)
`ifdef BSCAN_DEFRAME_STATS_EN
        ,
        .stat_msgs    (stat_msgs),
        .stat_drops   (stat_drops)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: one line per delivered beat, compared against the scoreboard.
    always @(negedge clk) begin
        if (nrst && err_zero_len) n_err_pulses++;
        if (nrst && out_ena) begin
            if (!out_rdy) check("ena_without_rdy", {31'd0, out_rdy}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_beat", out_v, 32'hFFFF_FFFF);
            end else begin
                entry_t e;
                e = sb.pop_front();
                $display("beat v=0x%08h chan=%0d last=%0b", out_v, out_chan, out_last);
                check("beat_data", out_v, e.data);
                check("beat_chan", {28'd0, out_chan}, {28'd0, e.chan});
                check("beat_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    // Offers a word only once RDY is seen, then holds ENA for exactly one edge.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        in_v = w;
        @(negedge clk);
        while (!in_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            in_ena = 1'b1;
            @(posedge clk);
            #1;
            in_ena = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [3:0] ch, input logic [31:0] d, input logic lst);
        entry_t e;
        e.data = d;
        e.chan = ch;
        e.last = lst;
        sb.push_back(e);
    endtask

    task automatic send_msg(input logic [3:0] ch, input int len, input logic [31:0] base);
        send_word({12'h000, ch, 16'(len)});
        for (int i = 0; i < len; i++) begin
            push_exp(ch, base + 32'(i), i == len - 1);
            send_word(base + 32'(i));
        end
        msgs_sent++;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_rdy",   {31'd0, in_rdy},       32'd1);
        check("rst_out_ena",  {31'd0, out_ena},      32'd0);
        check("rst_out_v",    out_v,                 32'd0);
        check("rst_out_chan", {28'd0, out_chan},     32'd0);
        check("rst_out_last", {31'd0, out_last},     32'd0);
        check("rst_err",      {31'd0, err_zero_len}, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // Reset in the middle of a message discards the buffered word.
        send_word(32'h0009_0003);
        send_word(32'h0000_DEAD);
        out_rdy = 1'b1;
        nrst = 1'b0;
        #1;
        check("mid_rst_out_ena", {31'd0, out_ena}, 32'd0);
        check("mid_rst_out_v",   out_v,            32'd0);
        check("mid_rst_chan",    {28'd0, out_chan}, 32'd0);
        check("mid_rst_in_rdy",  {31'd0, in_rdy},  32'd1);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        send_msg(4'd2, 1, 32'h0000_00AA);
        wait_drain("mid_rst_drain");

        // Basic message: each beat emerges one cycle after its input.
        send_msg(4'd5, 3, 32'h0000_0011);
        @(negedge clk); #1;
        check("basic_latency", sb.size(), 32'd0);

        // Zero-length header: single pulse, no beat, FSM stays in HDR.
        send_word(32'h0003_0000);
        @(negedge clk);
        check("zero_err_pulse", {31'd0, err_zero_len}, 32'd1);
        @(negedge clk);
        check("zero_err_clear", {31'd0, err_zero_len}, 32'd0);
        check("zero_no_beat",   {31'd0, out_ena},      32'd0);

        // Backpressure: FIFO fills after 4 payload words, then full push/pop.
        out_rdy = 1'b0;
        send_word(32'h0003_0006);
        for (int i = 0; i < 4; i++) begin
            push_exp(4'd3, 32'h100 + 32'(i), 1'b0);
            send_word(32'h100 + 32'(i));
        end
        @(negedge clk);
        check("full_in_rdy_low", {31'd0, in_rdy},  32'd0);
        check("full_no_out",     {31'd0, out_ena}, 32'd0);
        fork
            begin
                for (int i = 4; i < 6; i++) begin
                    push_exp(4'd3, 32'h100 + 32'(i), i == 5);
                    send_word(32'h100 + 32'(i));
                end
            end
            begin
                @(posedge clk); #1;
                out_rdy = 1'b1;
                @(negedge clk);
                check("full_pop_ena",   {31'd0, out_ena}, 32'd1);
                check("full_no_push",   {31'd0, in_rdy},  32'd0);
                @(negedge clk);
                check("after_pop_rdy",  {31'd0, in_rdy},  32'd1);
            end
        join
        msgs_sent++;
        wait_drain("bp_drain");

        // Back-to-back messages with continuous input.
        send_msg(4'd1, 2, 32'h0000_0A00);
        send_msg(4'd7, 1, 32'h0000_0B00);
        wait_drain("b2b_drain");

        // Random lengths and channels under random backpressure.
        bp_rand = 1'b1;
        for (int m = 0; m < 20; m++) begin
            send_msg(4'($urandom_range(0, 15)), int'($urandom_range(1, 7)), 32'($urandom));
        end
        bp_rand = 1'b0;
        @(posedge clk); #1;
        out_rdy = 1'b1;
        wait_drain("rand_drain");

        check("err_pulse_count", 32'(n_err_pulses), 32'd1);
`ifdef BSCAN_DEFRAME_STATS_EN
        check("stat_msgs",  {16'd0, stat_msgs},  32'(msgs_sent));
        check("stat_drops", {16'd0, stat_drops}, 32'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_rdy = 1'($urandom_range(0, 1));
        end
    end

endmodule
